// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register file and its debug read-out engine.
//   XLEN         register data width
//   REG_COUNT    number of architectural registers (x0..x31)
//   dump_state_t states of the regfile_dump walker
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int XLEN      = 32;
   localparam int REG_COUNT = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } dump_state_t;

endpackage : regfile_pkg

// File: rtl/regfile_dump_if.sv
// -----------------------------------------------------------------------------
// regfile_dump_if
// Bundles the dump engine's control, register-file read port and output stream.
//   start      request a dump (consumer -> engine)
//   rs/rdata   register-file read port (address out, combinational data in)
//   out_*      valid/ready beat stream carrying (address, data) pairs
//   busy/done  dump in progress / single-cycle completion pulse
// master: the dump engine.  slave: the register file / consumer side.
// -----------------------------------------------------------------------------
interface regfile_dump_if #(
   parameter int AW   = 5,
   parameter int XLEN = regfile_pkg::XLEN
) ();

   logic            start;
   logic [AW-1:0]   rs;
   logic [XLEN-1:0] rdata;
   logic            out_valid;
   logic            out_ready;
   logic [AW-1:0]   out_addr;
   logic [XLEN-1:0] out_data;
   logic            busy;
   logic            done;

   modport master (
      input  start, rdata, out_ready,
      output rs, out_valid, out_addr, out_data, busy, done
   );

   modport slave (
      output start, rdata, out_ready,
      input  rs, out_valid, out_addr, out_data, busy, done
   );

endinterface : regfile_dump_if

// File: rtl/regfile_dump.sv
// -----------------------------------------------------------------------------
// regfile_dump
// Debug read-out engine: on start, walks the register-file read port from x0
// to x(REG_COUNT-1) and streams each (address, data) pair over valid/ready.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   regfile_dump_if.master (start, rs/rdata, out_*, busy, done)
// Every output comes straight from a flop; nothing combinational reaches an
// output from out_ready or rdata.
// -----------------------------------------------------------------------------
module regfile_dump #(
   parameter int REG_COUNT = regfile_pkg::REG_COUNT,
   parameter int AW        = $clog2(REG_COUNT),
   parameter int XLEN      = regfile_pkg::XLEN
) (
   input  logic           clk,
   input  logic           rst,
   regfile_dump_if.master bus
);

   import regfile_pkg::*;

   localparam logic [AW-1:0] LAST_ADDR = AW'(REG_COUNT - 1);

   dump_state_t     state_q, state_d;
   logic [AW-1:0]   rs_q, rs_d;
   logic            valid_q, valid_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [XLEN-1:0] data_q, data_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of its neighbours regardless of process order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rs_q    <= '0;
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rs_q    <= rs_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // NOTE: every variable gets its hold value first so that no path through
   // the case statement leaves one unassigned (which would infer a latch).
   always_comb begin
      state_d = state_q;
      rs_d    = rs_q;
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = READ;
               rs_d    = '0;
            end
         end
         READ: begin
            // rdata answers rs in the same cycle; this snapshot is the beat,
            // so later writes to the register cannot disturb it.
            state_d = SEND;
            data_d  = bus.rdata;
            addr_d  = rs_q;
            valid_d = 1'b1;
         end
         SEND: begin
            if (valid_q && bus.out_ready) begin
               valid_d = 1'b0;
               if (addr_q == LAST_ADDR) begin
                  state_d = DONE;
               end else begin
                  rs_d    = rs_q + AW'(1);
                  state_d = READ;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // busy/done are decoded from the next state so they can be registered
      // and still line up with the state they describe.
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   assign bus.rs        = rs_q;
   assign bus.out_valid = valid_q;
   assign bus.out_addr  = addr_q;
   assign bus.out_data  = data_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule : regfile_dump

// File: tb/tb_regfile_dump.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump
// Directed bench for regfile_dump. A small register file with a clocked write
// port and a combinational read port sits on the slave side of the interface.
// -----------------------------------------------------------------------------
module tb_regfile_dump;

   localparam int AW   = 5;
   localparam int XLEN = 32;
   localparam int N    = 32;

   localparam logic [XLEN-1:0] X5_VAL  = 32'hDEADBEEF;
   localparam logic [XLEN-1:0] X10_OLD = 32'hCAFEBABE;
   localparam logic [XLEN-1:0] X10_NEW = 32'h12345678;

   logic clk = 1'b0;
   logic rst = 1'b1;

   regfile_dump_if #(.AW(AW), .XLEN(XLEN)) dif ();

   regfile_dump #(.REG_COUNT(N), .AW(AW), .XLEN(XLEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif)
   );

   always #5 clk = ~clk;

   // Register file model: clocked write port, combinational read port.
   logic [XLEN-1:0] rf [N];
   logic            we    = 1'b0;
   logic [AW-1:0]   waddr = '0;
   logic [XLEN-1:0] wdata = '0;

   always @(posedge clk) if (we) rf[waddr] <= wdata;
   assign dif.rdata = rf[dif.rs];

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int done_cnt    = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (dif.done) done_cnt <= done_cnt + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed time %0t required < 200000", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rf_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      we = 1'b1; waddr = a; wdata = d;
      tick();
      we = 1'b0;
   endtask

   // Waits (bounded) for a beat to be accepted; returns the handshake edge.
   task automatic wait_beat(input string tag, output int hs_edge,
                            output logic [AW-1:0] a, output logic [XLEN-1:0] d);
      logic got;
      got = 1'b0; hs_edge = -1; a = 'x; d = 'x;
      for (int w = 0; w < 8 && !got; w++) begin
         if (dif.out_valid && dif.out_ready) begin
            a = dif.out_addr;
            d = dif.out_data;
            got = 1'b1;
         end
         tick();
         if (got) hs_edge = cyc;
      end
      check({tag, " beat accepted"}, XLEN'(got), 32'd1);
   endtask

   // One complete dump with optional stall / start pulse / write during SEND.
   // exp10 is the value beat 10 must carry in this dump.
   task automatic run_dump(input string name, input int stall_beat, input int stall_cycles,
                           input int start_beat, input int write_beat,
                           input logic [XLEN-1:0] exp10);
      int              e0, extra, hs_edge, dc0;
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d, exp;
      dc0   = done_cnt;
      extra = 0;
      dif.out_ready = 1'b1;
      dif.start     = 1'b1;
      tick();
      dif.start = 1'b0;
      e0 = cyc;
      check({name, " busy after start"}, XLEN'(dif.busy), 32'd1);
      check({name, " no beat in READ"}, XLEN'(dif.out_valid), 32'd0);
      check({name, " rs starts at 0"}, XLEN'(dif.rs), 32'd0);
      for (int k = 0; k < N; k++) begin
         exp = (k == 5) ? X5_VAL : (k == 10) ? exp10 : '0;
         if (k == start_beat) dif.start = 1'b1;
         if (k == stall_beat) begin
            dif.out_ready = 1'b0;
            for (int w = 0; w < 4 && !dif.out_valid; w++) tick();
            for (int i = 0; i < stall_cycles; i++) begin
               check($sformatf("%s stall addr b%0d", name, k), XLEN'(dif.out_addr), XLEN'(k));
               check($sformatf("%s stall data b%0d", name, k), dif.out_data, exp);
               check($sformatf("%s stall rs b%0d", name, k), XLEN'(dif.rs), XLEN'(k));
               check($sformatf("%s stall valid b%0d", name, k), XLEN'(dif.out_valid), 32'd1);
               if (i == 0 && k == write_beat) begin
                  we = 1'b1; waddr = AW'(10); wdata = X10_NEW;
               end
               tick();
               we = 1'b0;
            end
            dif.out_ready = 1'b1;
            extra = stall_cycles;
         end
         wait_beat($sformatf("%s b%0d", name, k), hs_edge, a, d);
         dif.start = 1'b0;
         check($sformatf("%s addr b%0d", name, k), XLEN'(a), XLEN'(k));
         check($sformatf("%s data b%0d", name, k), d, exp);
         check($sformatf("%s edge b%0d", name, k), XLEN'(hs_edge - e0), XLEN'(2 + 2 * k + extra));
      end
      check({name, " done after last beat"}, XLEN'(dif.done), 32'd1);
      check({name, " busy during done"}, XLEN'(dif.busy), 32'd1);
      tick();
      check({name, " done is one cycle"}, XLEN'(dif.done), 32'd0);
      check({name, " busy low after done"}, XLEN'(dif.busy), 32'd0);
      check({name, " valid low in idle"}, XLEN'(dif.out_valid), 32'd0);
      tick();
      tick();
      check({name, " one done pulse"}, XLEN'(done_cnt - dc0), 32'd1);
      check({name, " stays idle"}, XLEN'(dif.busy), 32'd0);
   endtask

   initial begin
      int              hs_edge;
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;

      dif.start     = 1'b0;
      dif.out_ready = 1'b0;

      // Reset values.
      tick();
      tick();
      check("reset rs", XLEN'(dif.rs), 32'd0);
      check("reset valid", XLEN'(dif.out_valid), 32'd0);
      check("reset addr", XLEN'(dif.out_addr), 32'd0);
      check("reset data", dif.out_data, 32'd0);
      check("reset busy", XLEN'(dif.busy), 32'd0);
      check("reset done", XLEN'(dif.done), 32'd0);
      rst = 1'b0;
      tick();

      // Preload through the write port: all zero, then x5 and x10.
      for (int i = 0; i < N; i++) rf_write(AW'(i), '0);
      rf_write(AW'(5), X5_VAL);
      rf_write(AW'(10), X10_OLD);
      check("idle before dump", XLEN'(dif.busy), 32'd0);

      run_dump("full", -1, 0, -1, -1, X10_OLD);
      run_dump("bp", 5, 3, -1, -1, X10_OLD);
      run_dump("startbusy", -1, 0, 12, -1, X10_OLD);

      // Reset while beat 12 is valid.
      dif.out_ready = 1'b1;
      dif.start     = 1'b1;
      tick();
      dif.start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         wait_beat($sformatf("rstmid b%0d", k), hs_edge, a, d);
         check($sformatf("rstmid addr b%0d", k), XLEN'(a), XLEN'(k));
      end
      dif.out_ready = 1'b0;
      tick();
      check("rstmid beat 12 valid", XLEN'(dif.out_valid), 32'd1);
      check("rstmid beat 12 addr", XLEN'(dif.out_addr), 32'd12);
      rst = 1'b1;
      #1;
      check("rstmid rs", XLEN'(dif.rs), 32'd0);
      check("rstmid valid", XLEN'(dif.out_valid), 32'd0);
      check("rstmid addr", XLEN'(dif.out_addr), 32'd0);
      check("rstmid data", dif.out_data, 32'd0);
      check("rstmid busy", XLEN'(dif.busy), 32'd0);
      check("rstmid done", XLEN'(dif.done), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check("rstmid idle after release", XLEN'(dif.busy), 32'd0);
      run_dump("afterrst", -1, 0, -1, -1, X10_OLD);

      // Write x10 while its beat is stalled; the beat keeps the old value.
      run_dump("wrsend", 10, 2, -1, 10, X10_OLD);
      run_dump("newx10", -1, 0, -1, -1, X10_NEW);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_regfile_dump
